// File: rtl/window_loader.sv
// window_loader: buffers one window of BUFF_SIZE pixels, emits the four per-window control
// tokens, then replays the pixels in arrival order. Define WINDOW_LOADER_MEAN_PIVOT_EN for a mean pivot.
module window_loader #(
  parameter int BUFF_SIZE      = 1024,
  parameter int LOG2_BUFF_SIZE = 10,
  parameter int BUFF_SIZE_BIT  = 16,
  parameter int MEDIAN_POS     = 512,
  parameter int DEFAULT_PIVOT  = 127
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_px,
  input  logic                     in_px_empty,
  output logic                     in_px_rd,
  output logic [7:0]               out_px,
  output logic                     out_px_wr,
  input  logic                     out_px_full,
  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full,
  output logic                     loading,
  output logic                     sending
);
  localparam int CNT_W = LOG2_BUFF_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BUFF_SIZE - 1);

  typedef enum logic [1:0] {LOAD, HEADER, SEND} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [7:0]       buf_mem [BUFF_SIZE];
  // token vectors are ordered {second_median_value, median_pos, buff_size, pivot}
  logic [3:0]       pending, tok_full, tok_wr;
  logic             accept, load_last, send_last;
  logic [7:0]       pivot_calc;

  assign tok_full = {out_second_median_value_full, out_median_pos_full,
                     out_buff_size_full, out_pivot_full};
  assign out_pivot_wr               = tok_wr[0];
  assign out_buff_size_wr           = tok_wr[1];
  assign out_median_pos_wr          = tok_wr[2];
  assign out_second_median_value_wr = tok_wr[3];

  assign accept    = in_px_rd & ~in_px_empty;
  assign load_last = accept && (wr_cnt == LAST);
  assign send_last = out_px_wr && (rd_cnt == LAST);
  assign loading   = (state == LOAD);
  assign sending   = (state == SEND);
  assign out_px    = buf_mem[rd_cnt[LOG2_BUFF_SIZE-1:0]];

`ifdef WINDOW_LOADER_MEAN_PIVOT_EN
  localparam int SUM_W = 8 + LOG2_BUFF_SIZE;
  logic [SUM_W-1:0] sum, sum_next;

  assign sum_next   = sum + SUM_W'(in_px);
  assign pivot_calc = sum_next[LOG2_BUFF_SIZE +: 8];

  always_ff @(posedge clock) begin
    if (reset)       sum <= '0;
    else if (accept) sum <= load_last ? '0 : sum_next;
  end
`else
  assign pivot_calc = 8'(DEFAULT_PIVOT);
`endif

  always_ff @(posedge clock) begin
    if (accept) buf_mem[wr_cnt[LOG2_BUFF_SIZE-1:0]] <= in_px;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= LOAD;
      wr_cnt                  <= '0;
      rd_cnt                  <= '0;
      pending                 <= '0;
      out_pivot               <= '0;
      out_buff_size           <= '0;
      out_median_pos          <= '0;
      out_second_median_value <= '0;
    end else begin
      state <= state_next;
      if (accept)    wr_cnt <= load_last ? '0 : wr_cnt + CNT_W'(1);
      if (out_px_wr) rd_cnt <= send_last ? '0 : rd_cnt + CNT_W'(1);
      if (load_last) begin
        pending                 <= '1;
        out_pivot               <= pivot_calc;
        out_buff_size           <= BUFF_SIZE_BIT'(BUFF_SIZE);
        out_median_pos          <= BUFF_SIZE_BIT'(MEDIAN_POS);
        out_second_median_value <= '0;
      end else begin
        pending <= pending & ~tok_wr;
      end
    end
  end

  // HEADER leaves on the edge where every still-pending token is being written
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_last) state_next = HEADER;
      HEADER:  if ((pending & ~tok_wr) == '0) state_next = SEND;
      SEND:    if (send_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_px_rd  = 1'b0;
    out_px_wr = 1'b0;
    tok_wr    = '0;
    if (!reset) begin
      case (state)
        LOAD:    in_px_rd  = 1'b1;
        HEADER:  tok_wr    = pending & ~tok_full;
        SEND:    out_px_wr = ~out_px_full;
        default: ;
      endcase
    end
  end
endmodule
